fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Read side of the 8-bit scfifo (clock/sclr/rdreq/q/empty). Pops one byte whenever the FIFO is non-empty.
//  Serializes each byte as an async frame on tx: start, 8 data LSB-first, optional parity, stop.
//  Sits between the FIFO and the board TX pin. Drains the FIFO autonomously; no CPU handshake.
// PARAMETERS
//  DATA_W        8    byte width; must match FIFO q width
//  CLKS_PER_BIT  16   clock cycles per serial bit (>=2); counter width = $clog2(CLKS_PER_BIT)
//  STOP_BITS     1    stop bits per frame (1 or 2)
// PORTS
//  clock       in   1       single system clock, all logic on rising edge
//  sclr        in   1       synchronous reset, active-high
//  fifo_empty  in   1       FIFO empty flag
//  fifo_q      in   DATA_W  FIFO read data, valid the cycle after fifo_rdreq (normal, non-show-ahead mode)
//  fifo_rdreq  out  1       FIFO pop strobe, registered, one-cycle pulse
//  tx          out  1       serial line, idle high, registered
//  busy        out  1       high from REQ through last stop cycle
//  frame_done  out  1       one-cycle pulse on the final stop-bit cycle
// BEHAVIOUR
//  Reset (sclr=1 at an edge): state=IDLE, tx=1, fifo_rdreq=0, busy=0, frame_done=0, shift reg/counters=0.
//  Reset mid-frame aborts: tx=1 from next cycle, byte in flight is dropped (already popped, not re-read).
//  FSM states and transitions:
//   IDLE   : fifo_empty=0 -> REQ; else stay. fifo_empty is sampled ONLY in IDLE.
//   REQ    : fifo_rdreq=1 for exactly this cycle -> LOAD.
//   LOAD   : shift <= fifo_q -> START.
//   START  : tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA   : tx=shift[0]; shift right each bit period; after DATA_W bits -> PARITY (if enabled) else STOP.
//   PARITY : tx=parity bit for CLKS_PER_BIT cycles -> STOP.
//   STOP   : tx=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done on last cycle -> IDLE.
//  Bit counter counts 0..CLKS_PER_BIT-1 and wraps; data index counts 0..DATA_W-1.
//  fifo_rdreq is never asserted while fifo_empty=1, and never twice per frame; at most one outstanding pop.
//  Latency: fifo_empty falls at edge N (sampled in IDLE) -> fifo_rdreq high in cycle N+1 -> START (tx=0) from N+3.
//  Back-to-back: minimum inter-frame idle gap = 3 cycles (IDLE, REQ, LOAD) with tx=1.
//  busy=1 in REQ..STOP inclusive; 0 in IDLE.
//  FIFO full/almost_full are not consumed here; the writer side owns overflow.
//  Frame length (cycles) = CLKS_PER_BIT*(1+DATA_W+P+STOP_BITS), where P=1 if parity enabled, else 0.
// CONFIGURATION
//  UART_TX_PARITY_EN defined  : PARITY state present; parity = ^byte (even parity: total ones incl. parity even).
//  UART_TX_PARITY_EN undefined: PARITY state and its logic absent; DATA goes straight to STOP.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1)
//  1 Reset: sclr=1 for 5 cycles -> tx=1, fifo_rdreq=0, busy=0 throughout; stays idle while fifo_empty=1.
//  2 Single byte 0x56, no parity: fifo_rdreq one pulse.
//    tx sequence per 4-cycle bit = 0 | 0 1 1 0 1 0 1 0 | 1.
//    frame_done pulse at cycle 40 of frame; busy falls next cycle.
//  3 Burst 0x56,0xAA,0xFF,0xAA queued: exactly 4 rdreq pulses, 4 frames in order, 3-cycle tx=1 gap between frames.
//    fifo_empty rises after the 4th pop -> returns to IDLE.
//  4 UART_TX_PARITY_EN, byte 0x07 -> parity bit 1, frame 44 cycles; byte 0xAA -> parity bit 0.
//  5 sclr=1 during DATA bit 3 of 0xFF -> tx=1 next cycle, no frame_done.
//    After release with FIFO non-empty, the next byte is popped and sent as a full, clean frame.
//  6 fifo_empty toggling 1->0->1 while in STOP -> no extra rdreq; the pop occurs only after return to IDLE.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains an 8-bit scfifo (normal, non-show-ahead read mode) and serialises
// every byte as an asynchronous frame on tx:
//   start bit, DATA_W data bits LSB-first, optional even parity, stop bit(s).
// The block pops autonomously whenever the FIFO is non-empty; there is no
// CPU handshake. At most one pop is outstanding, and it covers one frame.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit(s). Without it, the parity
// state and its logic are not built.
//
// Parameters
//   DATA_W        byte width, must match the FIFO q width
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clock       in   system clock, all logic on the rising edge
//   sclr        in   synchronous reset, active-high
//   fifo_empty  in   FIFO empty flag, only looked at while idle
//   fifo_q      in   FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdreq  out  registered one-cycle pop strobe
//   tx          out  registered serial line, idle high
//   busy        out  high from the pop request through the last stop cycle
//   frame_done  out  one-cycle pulse on the final stop-bit cycle
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    // Index of the final stop bit; only bit 0 of the stop index is ever used.
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd6;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction
`endif

    logic [2:0]        state_r,    state_s;
    logic [CNT_W-1:0]  cnt_r,      cnt_s;
    logic [IDX_W-1:0]  idx_r,      idx_s;
    logic              stop_idx_r, stop_idx_s;
    logic [DATA_W-1:0] shift_r,    shift_s;
`ifdef UART_TX_PARITY_EN
    logic              parity_r,   parity_s;
`endif
    logic              tx_r,       tx_s;
    logic              rdreq_r;
    logic              busy_r;
    logic              frame_done_r, frame_done_s;

    assign fifo_rdreq = rdreq_r;
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Next-state, bit-timing and shift-register logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        stop_idx_s = stop_idx_r;
        shift_s    = shift_r;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // The empty flag is only consulted here, which is what keeps
                // a pop from ever being issued while a frame is in flight.
                if (!fifo_empty) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                // fifo_q holds the popped byte during this cycle.
                shift_s    = fifo_q;
`ifdef UART_TX_PARITY_EN
                parity_s   = even_parity(fifo_q);
`endif
                cnt_s      = CNT_ZERO;
                idx_s      = IDX_ZERO;
                stop_idx_s = 1'b0;
                state_s    = ST_START;
            end
            ST_START: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_DATA;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    shift_s = {1'b0, shift_r[DATA_W-1:1]};
                    if (idx_r == IDX_LAST) begin
                        idx_s      = IDX_ZERO;
                        stop_idx_s = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_s    = ST_PARITY;
`else
                        state_s    = ST_STOP;
`endif
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s      = CNT_ZERO;
                    stop_idx_s = 1'b0;
                    state_s    = ST_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (stop_idx_r == STOP_LAST) begin
                        stop_idx_s = 1'b0;
                        state_s    = ST_IDLE;
                    end else begin
                        stop_idx_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_s      = CNT_ZERO;
                idx_s      = IDX_ZERO;
                stop_idx_s = 1'b0;
                state_s    = ST_IDLE;
            end
        endcase
    end

    // Line level for the next cycle, decoded from the next state so tx stays registered.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_s = parity_s;
`endif
            default:   tx_s = 1'b1;
        endcase
    end

    // Final stop-bit cycle of the frame, decoded one cycle early for the register.
    always_comb begin
        if ((state_s == ST_STOP) && (cnt_s == CNT_LAST) && (stop_idx_s == STOP_LAST)) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // State and output registers with synchronous clear; a clear mid-frame drops the byte.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            idx_r        <= IDX_ZERO;
            stop_idx_r   <= 1'b0;
            shift_r      <= {DATA_W{1'b0}};
`ifdef UART_TX_PARITY_EN
            parity_r     <= 1'b0;
`endif
            tx_r         <= 1'b1;
            rdreq_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            idx_r        <= idx_s;
            stop_idx_r   <= stop_idx_s;
            shift_r      <= shift_s;
`ifdef UART_TX_PARITY_EN
            parity_r     <= parity_s;
`endif
            tx_r         <= tx_s;
            rdreq_r      <= (state_s == ST_REQ);
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= frame_done_s;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Bench for fifo_uart_tx with CLKS_PER_BIT=4, STOP_BITS=1. A small scfifo
// model feeds the DUT; bytes written to it are also queued as expected frames.
// A line monitor decodes every frame on tx (bit timing, stop, frame_done
// position, busy) and the test tasks pop and compare its records.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = CPB * (1 + DW + PAR_BITS + 1);

    logic       clock = 1'b0;
    logic       sclr  = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_q = 8'h00;
    logic       fifo_rdreq;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // FIFO model: wr_ptr written by the tasks, rd_ptr by the pop process.
    logic [7:0] mem [0:63];
    int         wr_ptr   = 0;
    int         rd_ptr   = 0;
    int         viol_cnt = 0;
    logic       rdreq_d  = 1'b0;
    bit         fake_ne  = 1'b0;

    logic [7:0] exp_q[$];

    // Monitor records.
    logic [7:0] rx_byte [0:63];
    logic       rx_par  [0:63];
    int         rx_err  [0:63];
    int         rx_gap  [0:63];
    int         rx_wr   = 0;
    int         rx_rd   = 0;
    int         fd_cnt  = 0;
    int         exp_fd  = 0;

    fifo_uart_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (1)
    ) dut (
        .clock      (clock),
        .sclr       (sclr),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    always_comb fifo_empty = (wr_ptr == rd_ptr) && !fake_ne;

    // scfifo read side: q updates the cycle after rdreq; flags illegal pops.
    always @(posedge clock) begin
        rdreq_d <= fifo_rdreq;
        if (fifo_rdreq === 1'b1) begin
            if (fifo_empty || rdreq_d) viol_cnt <= viol_cnt + 1;
            if (rd_ptr != wr_ptr) begin
                fifo_q <= mem[rd_ptr % 64];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    // Line monitor: decodes frames cycle by cycle, aborting on sclr.
    initial begin : monitor
        bit         active;
        int         c;
        int         p;
        int         ph;
        int         idle;
        int         gap;
        int         err;
        logic [7:0] b;
        logic       par;
        active = 1'b0; c = 0; idle = 0; gap = 0; err = 0; b = 8'h00; par = 1'b0;
        forever begin
            @(negedge clock);
            if (frame_done === 1'b1) fd_cnt++;
            if (sclr !== 1'b0) begin
                active = 1'b0;
                idle   = 0;
            end else begin
                if (!active && tx === 1'b0) begin
                    active = 1'b1; c = 0; err = 0; b = 8'h00; par = 1'b0; gap = idle;
                end
                if (!active) begin
                    idle++;
                end else begin
                    c++;
                    p  = (c - 1) / CPB;
                    ph = (c - 1) % CPB;
                    if (p == 0) begin
                        if (tx !== 1'b0) err |= 1;
                    end else if (p <= DW) begin
                        if (ph == 0) b[p-1] = tx;
                        else if (tx !== b[p-1]) err |= 2;
                    end else if (p <= DW + PAR_BITS) begin
                        if (ph == 0) par = tx;
                        else if (tx !== par) err |= 2;
                    end else begin
                        if (tx !== 1'b1) err |= 4;
                    end
                    if (frame_done !== ((c == FRAME_LEN) ? 1'b1 : 1'b0)) err |= 8;
                    if (busy !== 1'b1) err |= 16;
                    if (c == FRAME_LEN) begin
                        rx_byte[rx_wr % 64] = b;
                        rx_par[rx_wr % 64]  = par;
                        rx_err[rx_wr % 64]  = err;
                        rx_gap[rx_wr % 64]  = gap;
                        rx_wr++;
                        active = 1'b0;
                        idle   = 0;
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    // Pops the next monitor record (bounded wait) and compares it with exp.
    task automatic wait_frame(input logic [7:0] exp, input string name, output int gap);
        int t;
        t   = 0;
        gap = -1;
        while (rx_rd == rx_wr && t < 300) begin
            @(negedge clock); #1;
            t++;
        end
        tests_run++;
        if (rx_rd == rx_wr) begin
            tests_failed++;
            $display("FAIL %s timeout: no frame after %0d cycles, expected byte %02h", name, t, exp);
        end else begin
            exp_fd++;
            gap = rx_gap[rx_rd % 64];
            if (rx_byte[rx_rd % 64] !== exp) begin
                tests_failed++;
                $display("FAIL %s byte: got %02h expected %02h", name, rx_byte[rx_rd % 64], exp);
            end
            tests_run++;
            if (rx_err[rx_rd % 64] != 0) begin
                tests_failed++;
                $display("FAIL %s framing: error flags %0h expected 0", name, rx_err[rx_rd % 64]);
            end
`ifdef UART_TX_PARITY_EN
            tests_run++;
            if (rx_par[rx_rd % 64] !== ^exp) begin
                tests_failed++;
                $display("FAIL %s parity: got %0b expected %0b", name, rx_par[rx_rd % 64], ^exp);
            end
`endif
            rx_rd++;
        end
    endtask

    task automatic wait_tx_low(input string name);
        int t;
        t = 0;
        while (tx !== 1'b0 && t < 100) begin
            @(negedge clock); #1;
            t++;
        end
        tests_run++;
        if (tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s start: tx=%b expected 0 within 100 cycles", name, tx);
        end
    endtask

    task automatic test_reset();
        sclr = 1'b1;
        repeat (5) begin
            @(negedge clock);
            tests_run++;
            if (tx !== 1'b1 || fifo_rdreq !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset: tx=%b rdreq=%b busy=%b done=%b expected 1 0 0 0",
                         tx, fifo_rdreq, busy, frame_done);
            end
        end
        @(posedge clock); #1;
        sclr = 1'b0;
        repeat (10) begin
            @(negedge clock);
            tests_run++;
            if (tx !== 1'b1 || fifo_rdreq !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_empty: tx=%b rdreq=%b busy=%b expected 1 0 0", tx, fifo_rdreq, busy);
            end
        end
    endtask

    task automatic test_single();
        int gap;
        @(posedge clock); #1;
        push_byte(8'h56);
        @(negedge clock);
        tests_run++;
        if (fifo_rdreq !== 1'b0) begin
            tests_failed++;
            $display("FAIL single rdreq_early: got %b expected 0", fifo_rdreq);
        end
        @(negedge clock);
        tests_run++;
        if (fifo_rdreq !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single rdreq_pulse: rdreq=%b busy=%b expected 1 1", fifo_rdreq, busy);
        end
        @(negedge clock);
        tests_run++;
        if (fifo_rdreq !== 1'b0 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL single load: rdreq=%b tx=%b expected 0 1", fifo_rdreq, tx);
        end
        @(negedge clock);
        tests_run++;
        if (tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL single start_latency: tx=%b expected 0", tx);
        end
        wait_frame(exp_q.pop_front(), "single", gap);
        @(negedge clock); #1;
        tests_run++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL single busy_fall: busy=%b done=%b expected 0 0", busy, frame_done);
        end
        tests_run++;
        if (rd_ptr != 1) begin
            tests_failed++;
            $display("FAIL single pops: got %0d expected 1", rd_ptr);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        @(posedge clock); #1;
        push_byte(8'h56);
        push_byte(8'hAA);
        push_byte(8'hFF);
        push_byte(8'hAA);
        for (int i = 0; i < 4; i++) begin
            wait_frame(exp_q.pop_front(), "burst", gap);
            if (i > 0) begin
                tests_run++;
                if (gap != 3) begin
                    tests_failed++;
                    $display("FAIL burst gap%0d: got %0d idle cycles expected 3", i, gap);
                end
            end
        end
        repeat (6) @(negedge clock);
        tests_run++;
        if (busy !== 1'b0 || fifo_empty !== 1'b1 || rd_ptr != wr_ptr) begin
            tests_failed++;
            $display("FAIL burst drain: busy=%b empty=%b pops=%0d expected 0 1 %0d",
                     busy, fifo_empty, rd_ptr, wr_ptr);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int gap;
        @(posedge clock); #1;
        push_byte(8'h07);
        push_byte(8'hAA);
        wait_frame(exp_q.pop_front(), "parity_07", gap);
        wait_frame(exp_q.pop_front(), "parity_AA", gap);
    endtask
`endif

    task automatic test_reset_mid_frame();
        int gap;
        int fd_before;
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        push_byte(8'hFF);
        push_byte(8'h3C);
        wait_tx_low("abort");
        repeat (16) @(posedge clock);
        #1;
        fd_before = fd_cnt;
        sclr = 1'b1;
        @(negedge clock);
        @(negedge clock); #1;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || fifo_rdreq !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort state: tx=%b busy=%b done=%b rdreq=%b expected 1 0 0 0",
                     tx, busy, frame_done, fifo_rdreq);
        end
        @(posedge clock); #1;
        sclr = 1'b0;
        tests_run++;
        if (fd_cnt != fd_before) begin
            tests_failed++;
            $display("FAIL abort frame_done: got %0d pulses expected %0d", fd_cnt, fd_before);
        end
        void'(exp_q.pop_front());
        wait_frame(exp_q.pop_front(), "after_abort", gap);
        tests_run++;
        if (rd_ptr != wr_ptr) begin
            tests_failed++;
            $display("FAIL abort pops: got %0d expected %0d", rd_ptr, wr_ptr);
        end
    endtask

    task automatic test_stop_toggle();
        int gap;
        int cyc;
        int first_rd;
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        push_byte(8'h5A);
        wait_tx_low("stop_toggle");
        cyc      = 1;
        first_rd = -1;
        while (cyc < FRAME_LEN + 6) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == FRAME_LEN - 3) fake_ne = 1'b1;
            else if (cyc == FRAME_LEN - 2) fake_ne = 1'b0;
            if (cyc == FRAME_LEN - 1) push_byte(8'h81);
            @(negedge clock); #1;
            if (fifo_rdreq === 1'b1 && first_rd < 0) first_rd = cyc;
        end
        tests_run++;
        if (first_rd != FRAME_LEN + 2) begin
            tests_failed++;
            $display("FAIL stop_toggle pop_cycle: got %0d expected %0d", first_rd, FRAME_LEN + 2);
        end
        wait_frame(exp_q.pop_front(), "stop_toggle_1", gap);
        wait_frame(exp_q.pop_front(), "stop_toggle_2", gap);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_stop_toggle();
        repeat (10) @(negedge clock);
        tests_run++;
        if (viol_cnt != 0) begin
            tests_failed++;
            $display("FAIL rdreq_protocol: %0d illegal pops expected 0", viol_cnt);
        end
        tests_run++;
        if (fd_cnt != exp_fd || rx_wr != rx_rd) begin
            tests_failed++;
            $display("FAIL frame_count: done pulses %0d frames %0d expected %0d %0d",
                     fd_cnt, rx_wr, exp_fd, rx_rd);
        end
        tests_run++;
        if (rd_ptr != wr_ptr || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL final_idle: pops %0d busy %b expected %0d 0", rd_ptr, busy, wr_ptr);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
